// File: rtl/dram_rr_arbiter.sv
// Purpose: share one DRAM controller port between imem, dmem and loader with round-robin grants.
// Latency: request pulse in cycle 0 -> dram_oe in cycle 2; read data returns one cycle after dram_valid.
// Backpressure: one transaction in flight; later pulses stay latched per port until granted.
module dram_rr_arbiter #(
    parameter int MEM_SCALE = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    // imem port
    input  logic                 ioe,
    input  logic [MEM_SCALE-1:0] iaddr,
    output logic [31:0]          irdata,
    output logic                 ivalid,
    // dmem port
    input  logic                 doe,
    input  logic [MEM_SCALE-1:0] daddr,
    input  logic [31:0]          dwdata,
    input  logic [3:0]           dwe,
    output logic [31:0]          drdata,
    output logic                 dvalid,
    output logic                 dwritten,
    // loader port
    input  logic                 lreq,
    input  logic [MEM_SCALE-1:0] laddr,
    input  logic [31:0]          lwdata,
    input  logic [3:0]           lwe,
    output logic                 lwritten,
    output logic                 lbusy,
    // DRAM controller side
    output logic                 dram_oe,
    output logic [MEM_SCALE-1:0] dram_addr,
    output logic [31:0]          dram_wdata,
    output logic [3:0]           dram_we,
    input  logic [31:0]          dram_rdata,
    input  logic                 dram_valid,
    input  logic                 dram_written
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_IMEM = 2'd1, S_DMEM = 2'd2, S_LDR = 2'd3} state_t;

    localparam logic [1:0] G_I = 2'd0;
    localparam logic [1:0] G_D = 2'd1;
    localparam logic [1:0] G_L = 2'd2;

    state_t               state_q, state_d;
    logic [1:0]           last_q, last_d;
    logic                 i_pend_q, i_pend_d, d_pend_q, d_pend_d, l_pend_q, l_pend_d;
    logic [MEM_SCALE-1:0] iaddr_q, iaddr_d, daddr_q, daddr_d, laddr_q, laddr_d;
    logic [31:0]          dwdata_q, dwdata_d, lwdata_q, lwdata_d;
    logic [3:0]           dwe_q, dwe_d, lwe_q, lwe_d;
    logic                 dram_oe_q, dram_oe_d;
    logic [MEM_SCALE-1:0] dram_addr_q, dram_addr_d;
    logic [31:0]          dram_wdata_q, dram_wdata_d;
    logic [3:0]           dram_we_q, dram_we_d;
    logic                 ivalid_q, ivalid_d, dvalid_q, dvalid_d;
    logic [31:0]          irdata_q, irdata_d, drdata_q, drdata_d;
    logic                 gnt_i, gnt_d, gnt_l;
    logic                 done;

    assign done = dram_valid || dram_written;

    // Round-robin pick among pending ports, searching from the port after the last grant.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        gnt_l = 1'b0;
        if (state_q == S_IDLE) begin
            case (last_q)
                G_I: begin
                    if (d_pend_q)      gnt_d = 1'b1;
                    else if (l_pend_q) gnt_l = 1'b1;
                    else if (i_pend_q) gnt_i = 1'b1;
                end
                G_D: begin
                    if (l_pend_q)      gnt_l = 1'b1;
                    else if (i_pend_q) gnt_i = 1'b1;
                    else if (d_pend_q) gnt_d = 1'b1;
                end
                default: begin
                    if (i_pend_q)      gnt_i = 1'b1;
                    else if (d_pend_q) gnt_d = 1'b1;
                    else if (l_pend_q) gnt_l = 1'b1;
                end
            endcase
        end
    end

    // Per-port request latches; a pulse in the grant cycle re-arms the flag with the new fields.
    always_comb begin
        i_pend_d = i_pend_q;
        d_pend_d = d_pend_q;
        l_pend_d = l_pend_q;
        iaddr_d  = iaddr_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dwe_d    = dwe_q;
        laddr_d  = laddr_q;
        lwdata_d = lwdata_q;
        lwe_d    = lwe_q;
        if (ioe) begin
            i_pend_d = 1'b1;
            iaddr_d  = iaddr;
        end else if (gnt_i) begin
            i_pend_d = 1'b0;
        end
        if (doe) begin
            d_pend_d = 1'b1;
            daddr_d  = daddr;
            dwdata_d = dwdata;
            dwe_d    = dwe;
        end else if (gnt_d) begin
            d_pend_d = 1'b0;
        end
        if (lreq) begin
            l_pend_d = 1'b1;
            laddr_d  = laddr;
            lwdata_d = lwdata;
            lwe_d    = lwe;
        end else if (gnt_l) begin
            l_pend_d = 1'b0;
        end
    end

    // Next state: enter the granted port's service state, leave on any completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_i)      state_d = S_IMEM;
                else if (gnt_d) state_d = S_DMEM;
                else if (gnt_l) state_d = S_LDR;
            end
            default: begin
                if (done) state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: one-cycle command strobe on grant, registered read-done pulses and read data.
    always_comb begin
        dram_oe_d    = 1'b0;
        dram_we_d    = 4'h0;
        dram_addr_d  = dram_addr_q;
        dram_wdata_d = dram_wdata_q;
        last_d       = last_q;
        if (gnt_i) begin
            dram_oe_d   = 1'b1;
            dram_addr_d = iaddr_q;
            last_d      = G_I;
        end else if (gnt_d) begin
            dram_oe_d    = 1'b1;
            dram_addr_d  = daddr_q;
            dram_wdata_d = dwdata_q;
            dram_we_d    = dwe_q;
            last_d       = G_D;
        end else if (gnt_l) begin
            dram_oe_d    = 1'b1;
            dram_addr_d  = laddr_q;
            dram_wdata_d = lwdata_q;
            dram_we_d    = lwe_q;
            last_d       = G_L;
        end
        ivalid_d = (state_q == S_IMEM) && dram_valid;
        dvalid_d = (state_q == S_DMEM) && dram_valid;
        irdata_d = dram_rdata;
        drdata_d = dram_rdata;
    end

    // Control state with synchronous reset; pending requests are dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= G_L;
            i_pend_q  <= 1'b0;
            d_pend_q  <= 1'b0;
            l_pend_q  <= 1'b0;
            dram_oe_q <= 1'b0;
            dram_we_q <= 4'h0;
            ivalid_q  <= 1'b0;
            dvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            i_pend_q  <= i_pend_d;
            d_pend_q  <= d_pend_d;
            l_pend_q  <= l_pend_d;
            dram_oe_q <= dram_oe_d;
            dram_we_q <= dram_we_d;
            ivalid_q  <= ivalid_d;
            dvalid_q  <= dvalid_d;
        end
    end

    // Datapath registers carry no reset; their contents only matter alongside a strobe.
    always_ff @(posedge clk) begin
        iaddr_q      <= iaddr_d;
        daddr_q      <= daddr_d;
        dwdata_q     <= dwdata_d;
        dwe_q        <= dwe_d;
        laddr_q      <= laddr_d;
        lwdata_q     <= lwdata_d;
        lwe_q        <= lwe_d;
        dram_addr_q  <= dram_addr_d;
        dram_wdata_q <= dram_wdata_d;
        irdata_q     <= irdata_d;
        drdata_q     <= drdata_d;
    end

    assign dram_oe    = dram_oe_q;
    assign dram_addr  = dram_addr_q;
    assign dram_wdata = dram_wdata_q;
    assign dram_we    = dram_we_q;
    assign ivalid     = ivalid_q;
    assign dvalid     = dvalid_q;
    assign irdata     = irdata_q;
    assign drdata     = drdata_q;
    assign dwritten   = dram_written && (state_q == S_DMEM);
    assign lwritten   = dram_written && (state_q == S_LDR);
    assign lbusy      = l_pend_q || (state_q == S_LDR);

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Purpose: directed self-checking bench for dram_rr_arbiter (cycle table plus multi-cycle sequences).
// Latency: inputs driven 1 time unit after posedge, outputs sampled on the following negedge.
// Backpressure: the bench plays the DRAM controller and answers each command a few cycles later.
module tb_dram_rr_arbiter;

    localparam int MS = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic          ioe, doe, lreq;
    logic [MS-1:0] iaddr, daddr, laddr;
    logic [31:0]   dwdata, lwdata;
    logic [3:0]    dwe, lwe;
    logic [31:0]   irdata, drdata;
    logic          ivalid, dvalid, dwritten, lwritten, lbusy;
    logic          dram_oe;
    logic [MS-1:0] dram_addr;
    logic [31:0]   dram_wdata;
    logic [3:0]    dram_we;
    logic [31:0]   dram_rdata;
    logic          dram_valid, dram_written;

    int n_checks = 0;
    int n_fail   = 0;

    dram_rr_arbiter #(.MEM_SCALE(MS)) dut (
        .clk(clk), .rst(rst),
        .ioe(ioe), .iaddr(iaddr), .irdata(irdata), .ivalid(ivalid),
        .doe(doe), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
        .drdata(drdata), .dvalid(dvalid), .dwritten(dwritten),
        .lreq(lreq), .laddr(laddr), .lwdata(lwdata), .lwe(lwe),
        .lwritten(lwritten), .lbusy(lbusy),
        .dram_oe(dram_oe), .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
        .dram_rdata(dram_rdata), .dram_valid(dram_valid), .dram_written(dram_written)
    );

    always #5 clk = ~clk;

    // A loader pulse while its previous request is still outstanding is illegal stimulus.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(lreq && lbusy && !lwritten))
                else $error("FAIL ldr_protocol: lreq pulsed while a loader request is outstanding");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rst, ioe, doe, lreq;
        logic [MS-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    we;
        logic [31:0]   rdata;
        logic          valid, written;
        logic          e_oe;
        logic [MS-1:0] e_addr;
        logic [31:0]   e_wdata;
        logic [3:0]    e_we;
        logic          e_iv, e_dv;
        logic [31:0]   e_rdata;
        logic          e_dwr, e_lwr, e_lbusy;
    } vec_t;

    localparam int NV = 26;
    vec_t vt[NV];

    logic [MS-1:0] port_addr[3];
    logic [31:0]   rd_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        ioe = 0; doe = 0; lreq = 0;
        iaddr = '0; daddr = '0; laddr = '0;
        dwdata = '0; lwdata = '0; dwe = '0; lwe = '0;
        dram_rdata = '0; dram_valid = 0; dram_written = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    // Port 0 = imem read, 1 = dmem full-word write, 2 = loader write.
    task automatic pulse(input int port);
        case (port)
            0: begin ioe = 1; iaddr = port_addr[0]; end
            1: begin doe = 1; daddr = port_addr[1]; dwdata = 32'hD0D0_1111; dwe = 4'hF; end
            default: begin lreq = 1; laddr = port_addr[2]; lwdata = 32'hC0C0_2222; lwe = 4'hF; end
        endcase
    endtask

    // Wait for the next command, check it belongs to the expected port, then complete it.
    task automatic run_txn(input int port, input bit repulse);
        int  n    = 0;
        bit  seen = 0;
        while (!seen && n < 12) begin
            @(negedge clk);
            if (dram_oe === 1'b1) seen = 1;
            else begin next_cycle(); n++; end
        end
        check($sformatf("grant_seen_p%0d", port), 64'(seen), 64'd1);
        if (seen) begin
            check($sformatf("grant_addr_p%0d", port), 64'(dram_addr), 64'(port_addr[port]));
            check($sformatf("grant_we_p%0d", port), 64'(dram_we), (port == 0) ? 64'd0 : 64'hF);
            next_cycle();
            @(negedge clk);
            check("single_oe", 64'(dram_oe), 64'd0);
            next_cycle();
            clr_in();
            if (port == 0) begin dram_valid = 1; dram_rdata = rd_word; end
            else dram_written = 1;
            if (repulse) pulse(port);
            @(negedge clk);
            if (port == 1) check("dwritten_done", 64'(dwritten), 64'd1);
            if (port == 2) begin
                check("lwritten_done", 64'(lwritten), 64'd1);
                check("lbusy_at_done", 64'(lbusy), 64'd1);
            end
            next_cycle();
            clr_in();
            @(negedge clk);
            if (port == 0) begin
                check("ivalid_done", 64'(ivalid), 64'd1);
                check("irdata_done", 64'(irdata), 64'(rd_word));
            end
            if (port == 1) check("dvalid_on_write", 64'(dvalid), 64'd0);
            if (port == 2 && !repulse) check("lbusy_fall", 64'(lbusy), 64'd0);
            rd_word = rd_word + 32'h0101_0101;
        end
    endtask

    initial begin
        int oe_cnt;
        int seq_i[9];
        port_addr[0] = 27'h11;
        port_addr[1] = 27'h22;
        port_addr[2] = 27'h33;
        rd_word = 32'hA5A5_0000;
        seq_i = '{0, 1, 2, 0, 1, 2, 0, 1, 2};

        //        rst ioe doe lrq addr    wdata         we     rdata         v  w | oe addr   wdata         we     iv dv rdata         dw lw lb
        vt[0]  = '{1, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 'h100,  0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  1, 'h100, 0,            0,     0, 0, 0,            0, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[5]  = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[6]  = '{0, 0, 0, 0, 0,      0,            0,     'hDEADBEEF,   1, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[7]  = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     1, 0, 'hDEADBEEF,   0, 0, 0};
        vt[8]  = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[9]  = '{0, 0, 1, 0, 'h20,   'h12345678,   4'h3,  0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[10] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[11] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  1, 'h20,  'h12345678,   4'h3,  0, 0, 0,            0, 0, 0};
        vt[12] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 1,  0, 0,     0,            0,     0, 0, 0,            1, 0, 0};
        vt[13] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[14] = '{0, 0, 0, 1, 'h7,    'hCAFEF00D,   4'hF,  0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[15] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 1};
        vt[16] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  1, 'h7,   'hCAFEF00D,   4'hF,  0, 0, 0,            0, 0, 1};
        vt[17] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 1,  0, 0,     0,            0,     0, 0, 0,            0, 1, 1};
        vt[18] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[19] = '{0, 0, 0, 0, 0,      0,            0,     'h1111,       1, 1,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[20] = '{0, 0, 1, 0, 'h44,   0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[21] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[22] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  1, 'h44,  0,            0,     0, 0, 0,            0, 0, 0};
        vt[23] = '{0, 0, 0, 0, 0,      0,            0,     'h55AA55AA,   1, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};
        vt[24] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 1, 'h55AA55AA,   0, 0, 0};
        vt[25] = '{0, 0, 0, 0, 0,      0,            0,     0,            0, 0,  0, 0,     0,            0,     0, 0, 0,            0, 0, 0};

        clr_in();
        rst = 1;
        next_cycle();
        next_cycle();

        // Cycle table: reset state, imem read, dmem write, loader write, stale response, dmem read.
        for (int k = 0; k < NV; k++) begin
            rst = vt[k].rst;
            ioe = vt[k].ioe; doe = vt[k].doe; lreq = vt[k].lreq;
            iaddr = vt[k].addr; daddr = vt[k].addr; laddr = vt[k].addr;
            dwdata = vt[k].wdata; lwdata = vt[k].wdata;
            dwe = vt[k].we; lwe = vt[k].we;
            dram_rdata = vt[k].rdata; dram_valid = vt[k].valid; dram_written = vt[k].written;
            @(negedge clk);
            check($sformatf("row%0d_oe", k), 64'(dram_oe), 64'(vt[k].e_oe));
            check($sformatf("row%0d_we", k), 64'(dram_we), 64'(vt[k].e_we));
            check($sformatf("row%0d_ivalid", k), 64'(ivalid), 64'(vt[k].e_iv));
            check($sformatf("row%0d_dvalid", k), 64'(dvalid), 64'(vt[k].e_dv));
            check($sformatf("row%0d_dwritten", k), 64'(dwritten), 64'(vt[k].e_dwr));
            check($sformatf("row%0d_lwritten", k), 64'(lwritten), 64'(vt[k].e_lwr));
            check($sformatf("row%0d_lbusy", k), 64'(lbusy), 64'(vt[k].e_lbusy));
            if (vt[k].e_oe) begin
                check($sformatf("row%0d_addr", k), 64'(dram_addr), 64'(vt[k].e_addr));
                if (vt[k].e_we != 4'h0)
                    check($sformatf("row%0d_wdata", k), 64'(dram_wdata), 64'(vt[k].e_wdata));
            end
            if (vt[k].e_iv) check($sformatf("row%0d_irdata", k), 64'(irdata), 64'(vt[k].e_rdata));
            if (vt[k].e_dv) check($sformatf("row%0d_drdata", k), 64'(drdata), 64'(vt[k].e_rdata));
            next_cycle();
        end

        // Fairness: all three pulsed from reset and re-pulsed at completion -> I,D,L repeating.
        do_reset();
        pulse(0); pulse(1); pulse(2);
        next_cycle();
        clr_in();
        for (int t = 0; t < 9; t++) run_txn(seq_i[t], 1'b1);

        // Loader streaming against a persistent imem requester -> I,L alternating.
        do_reset();
        pulse(0); pulse(2);
        next_cycle();
        clr_in();
        for (int t = 0; t < 6; t++) run_txn((t % 2 == 0) ? 0 : 2, (t != 5));

        // Same-cycle re-request: second imem pulse in the grant cycle yields a second command.
        do_reset();
        ioe = 1; iaddr = 27'h100;
        next_cycle();
        ioe = 1; iaddr = 27'h200;
        @(negedge clk);
        check("rereq_no_oe_c1", 64'(dram_oe), 64'd0);
        next_cycle();
        clr_in();
        @(negedge clk);
        check("rereq_oe1", 64'(dram_oe), 64'd1);
        check("rereq_addr1", 64'(dram_addr), 64'h100);
        next_cycle();
        next_cycle();
        dram_valid = 1; dram_rdata = 32'h0BAD_F00D;
        next_cycle();
        clr_in();
        @(negedge clk);
        check("rereq_ivalid", 64'(ivalid), 64'd1);
        check("rereq_no_oe_c5", 64'(dram_oe), 64'd0);
        next_cycle();
        @(negedge clk);
        check("rereq_oe2", 64'(dram_oe), 64'd1);
        check("rereq_addr2", 64'(dram_addr), 64'h200);
        next_cycle();
        dram_valid = 1;
        next_cycle();
        clr_in();

        // Reset in the middle of a dmem read with other requests queued and a late response.
        do_reset();
        doe = 1; daddr = 27'h30; dwe = 4'h0;
        next_cycle();
        clr_in();
        next_cycle();
        ioe = 1; iaddr = 27'h40;
        lreq = 1; laddr = 27'h50; lwe = 4'hF; lwdata = 32'h1;
        @(negedge clk);
        check("rst_seq_oe", 64'(dram_oe), 64'd1);
        check("rst_seq_addr", 64'(dram_addr), 64'h30);
        next_cycle();
        clr_in();
        rst = 1;
        @(negedge clk);
        check("rst_seq_lbusy_pre", 64'(lbusy), 64'd1);
        next_cycle();
        rst = 0;
        @(negedge clk);
        check("rst_seq_lbusy_post", 64'(lbusy), 64'd0);
        check("rst_seq_dvalid0", 64'(dvalid), 64'd0);
        next_cycle();
        next_cycle();
        dram_valid = 1; dram_rdata = 32'h7777_7777;
        oe_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dram_oe !== 1'b0) oe_cnt++;
            if (c == 1) check("rst_seq_late_dvalid", 64'(dvalid), 64'd0);
            next_cycle();
            clr_in();
        end
        check("rst_seq_oe_count", 64'(oe_cnt), 64'd0);
        @(negedge clk);
        check("rst_seq_lbusy_end", 64'(lbusy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
